// File: rtl/ram_port_arbiter.sv
// Fetch/data port arbiter in front of a single-ported RAM with a MOC completion handshake.
// Optional feature macro ALIGN_CHECK_EN: misaligned data accesses fault, fetches are word-aligned.
module ram_port_arbiter #(
    parameter int READ_WAIT = 1,
    parameter int TIMEOUT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_mode,
    input  logic [7:0]  d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_fault,
    output logic [31:0] d_rdata,
    output logic        ram_en,
    output logic        ram_rw,
    output logic [1:0]  ram_mode,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_moc
);
    localparam int CNT_W = $clog2(READ_WAIT + TIMEOUT + 2) + 1;
    localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(READ_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t           state, next_state;
    logic             grant_data;
    logic [CNT_W-1:0] wait_cnt;
    logic             pick_data, pick_fetch, skip, capture, time_out;
    logic             bad_data;
    logic [7:0]       fetch_addr;

`ifdef ALIGN_CHECK_EN
    assign fetch_addr = {if_addr[7:2], 2'b00};
    assign bad_data   = (d_mode == 2'b11)
                     || (d_mode == 2'b01 && d_addr[0])
                     || (d_mode == 2'b10 && d_addr[1:0] != 2'b00);
`else
    assign fetch_addr = if_addr;
    assign bad_data   = (d_mode == 2'b11);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        ram_en     = 1'b0;
        if_ack     = 1'b0;
        d_ack      = 1'b0;
        pick_data  = 1'b0;
        pick_fetch = 1'b0;
        skip       = 1'b0;
        capture    = 1'b0;
        time_out   = 1'b0;
        case (state)
            IDLE: begin
                // On a tie the port that was not granted last wins; grant_data holds the last grant.
                if (d_req && (!if_req || !grant_data)) pick_data  = 1'b1;
                else if (if_req)                        pick_fetch = 1'b1;
                if (pick_data && bad_data) begin
                    skip       = 1'b1;
                    next_state = DONE;
                end else if (pick_data || pick_fetch) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                ram_en     = 1'b1;
                next_state = WAIT;
            end
            WAIT: begin
                ram_en = 1'b1;
                if (ram_rw) begin
                    if (wait_cnt == READ_LAST) begin
                        capture    = 1'b1;
                        next_state = DONE;
                    end
                end else if (wait_cnt != '0 && ram_moc) begin
                    next_state = DONE;
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    time_out   = 1'b1;
                    next_state = DONE;
                end
            end
            DONE: begin
                if_ack     = !grant_data;
                d_ack      = grant_data;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Skipped data requests never reach the RAM, so the bus registers keep their old values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_data <= 1'b0;
            ram_rw     <= 1'b1;
            ram_mode   <= 2'b00;
            ram_addr   <= 8'h00;
            ram_wdata  <= 32'h0;
            wait_cnt   <= '0;
            d_fault    <= 1'b0;
            d_rdata    <= 32'h0;
            if_rdata   <= 32'h0;
        end else begin
            if (pick_data) begin
                grant_data <= 1'b1;
                if (!skip) begin
                    ram_rw    <= d_rw;
                    ram_mode  <= d_mode;
                    ram_addr  <= d_addr;
                    ram_wdata <= d_wdata;
                end
            end
            if (pick_fetch) begin
                grant_data <= 1'b0;
                ram_rw     <= 1'b1;
                ram_mode   <= 2'b10;
                ram_addr   <= fetch_addr;
            end
            wait_cnt <= (state == WAIT && next_state == WAIT) ? wait_cnt + CNT_W'(1) : '0;
            if (capture) begin
                if (grant_data) d_rdata  <= ram_rdata;
                else            if_rdata <= ram_rdata;
            end
            if (skip)
                d_fault <= 1'b1;
            else if (state == WAIT && next_state == DONE && grant_data)
                d_fault <= time_out;
        end
    end
endmodule
